// File: rtl/poly_pkg.sv
// poly_pkg: shared types, operand indices and default phase lengths for the polynomial operand feeder
package poly_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE_HI, DRIVE_LO, SETTLE, DONE} state_t;
  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;
  localparam logic [1:0] OP_X = 2'd3;
  localparam int DEF_GO_HIGH = 2;
  localparam int DEF_GO_LOW = 2;
  localparam int DEF_SETTLE = 6;
  function automatic logic [7:0] op_sel(input logic [1:0] idx, input logic [7:0] a, b, c, x);
    return idx == OP_A ? a : idx == OP_B ? b : idx == OP_C ? c : x;
  endfunction
endpackage

// File: rtl/phase_counter.sv
// phase_counter: loadable down-counter that parks at zero and flags it
module phase_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);
  logic [W-1:0] count_q, count_d;
  assign count_d = load_i ? value_i : (count_q != '0) ? count_q - W'(1) : count_q;
  assign zero_o = count_q == '0;
  // load wins over the decrement so a phase change restarts the count on the same edge
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else count_q <= count_d;
  end
endmodule

// File: rtl/poly_operand_feeder.sv
// poly_operand_feeder: replays four parallel operands to the polynomial evaluator as go phases and captures its result
module poly_operand_feeder
  import poly_pkg::*;
#(
  parameter int GO_HIGH_CYCLES = DEF_GO_HIGH,
  parameter int GO_LOW_CYCLES  = DEF_GO_LOW,
  parameter int SETTLE_CYCLES  = DEF_SETTLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic [7:0] c_in,
  input  logic [7:0] x_in,
  input  logic [7:0] data_result,
  output logic [7:0] data_in,
  output logic       go,
  output logic       busy,
  output logic       done,
  output logic [7:0] result
);
  localparam int HL = GO_HIGH_CYCLES > GO_LOW_CYCLES ? GO_HIGH_CYCLES : GO_LOW_CYCLES;
  localparam int MAXP = HL > SETTLE_CYCLES ? HL : SETTLE_CYCLES;
  localparam int CW = MAXP > 1 ? $clog2(MAXP) : 1;
  localparam logic [CW-1:0] HI_LD = CW'(GO_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LO_LD = CW'(GO_LOW_CYCLES - 1);
  localparam logic [CW-1:0] ST_LD = CW'(SETTLE_CYCLES - 1);
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] a_q, b_q, c_q, x_q;
  logic [7:0] din_q, din_d;
  logic [7:0] result_q;
  logic [CW-1:0] ld_val;
  logic ld, cnt_zero, accept;
  phase_counter #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst    (reset),
    .load_i (ld),
    .value_i(ld_val),
    .zero_o (cnt_zero)
  );
  assign accept = state_q == IDLE && start;
  // phase sequencing: every state change reloads the counter with the next phase length
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    ld = 1'b0;
    ld_val = HI_LD;
    case (state_q)
      IDLE: if (start) begin
        state_d = DRIVE_HI;
        idx_d = OP_A;
        ld = 1'b1;
      end
      DRIVE_HI: if (cnt_zero) begin
        state_d = DRIVE_LO;
        ld = 1'b1;
        ld_val = LO_LD;
      end
      DRIVE_LO: if (cnt_zero) begin
        ld = 1'b1;
        state_d = idx_q == OP_X ? SETTLE : DRIVE_HI;
        ld_val = idx_q == OP_X ? ST_LD : HI_LD;
        idx_d = idx_q == OP_X ? idx_q : idx_q + 2'd1;
      end
      SETTLE: if (cnt_zero) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // the accepting edge has no latched operands yet, so A comes straight from the input
  assign din_d = accept ? a_in
               : (state_d == DRIVE_HI || state_d == DRIVE_LO) ? op_sel(idx_d, a_q, b_q, c_q, x_q)
               : 8'h00;
  // state, operand latch, presented operand and captured result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= OP_A;
      {a_q, b_q, c_q, x_q} <= '0;
      din_q <= 8'h00;
      result_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      din_q <= din_d;
      if (accept) {a_q, b_q, c_q, x_q} <= {a_in, b_in, c_in, x_in};
      if (state_q == SETTLE && cnt_zero) result_q <= data_result;
    end
  end
  assign data_in = din_q;
  assign go = state_q == DRIVE_HI;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign result = result_q;
endmodule

// File: tb/tb_poly_operand_feeder.sv
// tb_poly_operand_feeder: feeders (default and 1/1/6 phases) driving behavioural evaluators, scoreboarded results
module tb_poly_operand_feeder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] start = '0;
  logic [7:0] a = 0, b = 0, c = 0, x = 0;
  logic [1:0][7:0] din, res;
  logic [1:0] go, busy, done;
  logic [7:0] q0[$], q1[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : ev
    logic [7:0] din_l, res_l, dr;
    logic go_l, busy_l, done_l, gp;
    logic [7:0] op [4];
    logic [2:0] slot, cd;
    poly_operand_feeder #(
      .GO_HIGH_CYCLES(g == 0 ? 2 : 1),
      .GO_LOW_CYCLES (g == 0 ? 2 : 1),
      .SETTLE_CYCLES (6)
    ) dut (
      .clk(clk), .reset(reset), .start(start[g]),
      .a_in(a), .b_in(b), .c_in(c), .x_in(x),
      .data_result(dr), .data_in(din_l), .go(go_l),
      .busy(busy_l), .done(done_l), .result(res_l)
    );
    // evaluator: loads each operand on a go rise, leaves X-wait on the first X low edge, loads 5 edges later
    always @(posedge clk) begin
      if (reset) begin
        slot <= 0; cd <= 0; gp <= 0; dr <= 8'h00;
      end else begin
        gp <= go_l;
        if (go_l && !gp && slot < 4) begin
          op[slot[1:0]] <= din_l;
          slot <= slot + 3'd1;
        end else if (slot == 4 && !go_l) begin
          slot <= 5; cd <= 4;
        end else if (slot == 5) begin
          if (cd != 0) cd <= cd - 3'd1;
          else begin
            dr <= 8'(op[2] * op[3] * op[3] + op[1] * op[3] + op[0]);
            slot <= 0;
          end
        end
      end
    end
    assign din[g] = din_l;
    assign res[g] = res_l;
    assign go[g] = go_l;
    assign busy[g] = busy_l;
    assign done[g] = done_l;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept edge is E0; returns in cycle 1
  task automatic issue(input int g, input logic [7:0] ia, ib, ic, ix, input logic [7:0] e);
    a = ia; b = ib; c = ic; x = ix;
    start[g] = 1'b1;
    if (g == 0) q0.push_back(e); else q1.push_back(e);
    tick();
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int g, input int k0, input int exp);
    int k = k0;
    while (!done[g] && k < k0 + 60) begin
      tick();
      k++;
    end
    chk(nm, k, exp);
  endtask

  // scoreboard monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done[0]) begin
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL mon0_unexpected_done: result %0h with nothing expected", res[0]);
      end else chk("mon0_result", res[0], q0.pop_front());
    end
    if (done[1]) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL mon1_unexpected_done: result %0h with nothing expected", res[1]);
      end else chk("mon1_result", res[1], q1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      chk("rst_go", go[g], 0);
      chk("rst_din", din[g], 0);
      chk("rst_busy", busy[g], 0);
      chk("rst_done", done[g], 0);
      chk("rst_result", res[g], 0);
    end
    reset = 1'b0;
    tick();
    // basic run with full per-cycle waveform check
    issue(0, 8'd1, 8'd2, 8'd3, 8'd4, 8'h39);
    for (int k = 1; k <= 23; k++) begin
      chk("t1_go", go[0], k <= 16 && ((k - 1) % 4) < 2);
      chk("t1_din", din[0], k <= 16 ? (k - 1) / 4 + 1 : 0);
      chk("t1_busy", busy[0], 1);
      chk("t1_done", done[0], k == 23);
      if (k < 23) tick();
    end
    tick();
    chk("t1_idle_busy", busy[0], 0);
    // 8-bit wrap
    issue(0, 8'hFF, 8'h10, 8'h20, 8'h10, 8'hFF);
    wait_done("t2_done_cycle", 0, 1, 23);
    tick();
    // start held high: back-to-back runs, operands changed after first acceptance
    a = 1; b = 2; c = 3; x = 4;
    start[0] = 1'b1;
    q0.push_back(8'h39);
    q0.push_back(8'hF5);
    tick();
    a = 5; b = 6; c = 7; x = 8;
    for (int k = 1; k <= 49; k++) begin
      if (k == 1) chk("t3_din_first", din[0], 1);
      if (k == 23) chk("t3_done1", done[0], 1);
      if (k == 24) chk("t3_gap_go", go[0], 0);
      if (k == 24) chk("t3_gap_busy", busy[0], 0);
      if (k == 25) chk("t3_go2_rise", go[0], 1);
      if (k == 25) chk("t3_din2", din[0], 5);
      if (k == 25) start[0] = 1'b0;
      if (k == 30 || k == 46) chk("t3_result_hold", res[0], 8'h39);
      if (k == 47) chk("t3_done2", done[0], 1);
      if (k == 49) chk("t3_no_third", busy[0], 0);
      if (k < 49) tick();
    end
    // stray start mid-run and operand changes are ignored
    issue(0, 8'd1, 8'd2, 8'd3, 8'd4, 8'h39);
    repeat (7) tick();
    start[0] = 1'b1;
    a = 9; b = 9; c = 9; x = 9;
    tick();
    start[0] = 1'b0;
    chk("t4_din_c", din[0], 3);
    repeat (4) tick();
    chk("t4_din_x", din[0], 4);
    wait_done("t4_done_cycle", 0, 13, 23);
    seen = 0;
    repeat (30) begin
      tick();
      if (busy[0]) seen++;
    end
    chk("t4_no_extra_run", seen, 0);
    // reset mid-run
    issue(0, 8'd1, 8'd2, 8'd3, 8'd4, 8'h39);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    chk("t5_go", go[0], 0);
    chk("t5_busy", busy[0], 0);
    chk("t5_result", res[0], 0);
    void'(q0.pop_back());
    reset = 1'b0;
    tick();
    issue(0, 8'd1, 8'd2, 8'd3, 8'd4, 8'h39);
    wait_done("t5_done_cycle", 0, 1, 23);
    tick();
    // short phases 1/1/6
    issue(1, 8'd1, 8'd2, 8'd3, 8'd4, 8'h39);
    for (int k = 1; k <= 15; k++) begin
      chk("t6_go", go[1], k <= 8 && (k % 2) == 1);
      chk("t6_din", din[1], k <= 8 ? (k + 1) / 2 : 0);
      chk("t6_done", done[1], k == 15);
      if (k < 15) tick();
    end
    tick();
    issue(1, 8'hFF, 8'h10, 8'h20, 8'h10, 8'hFF);
    wait_done("t6_wrap_done_cycle", 1, 1, 15);
    repeat (3) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/poly_operand_feeder.md
# poly_operand_feeder

Sequencer that sits directly upstream of the polynomial evaluator (the `data_in`/`go` consumer that computes C·X² + B·X + A in 8 bits).
- Accepts four operands in parallel on a single `start` request.
- Replays them to the evaluator as the serial `go`-pulse protocol it expects: A, B, C, X, each held through a go-high and a go-low phase.
- Waits for the evaluator's compute cycles, then captures `data_result` into a held result register and pulses `done`.

Replaces manual KEY/switch stepping on the board top.

## Interface
Parameters:
- `GO_HIGH_CYCLES`, default 2: cycles `go` is held high per operand; must be ≥1.
- `GO_LOW_CYCLES`, default 2: cycles `go` is held low after each high phase; must be ≥1.
- `SETTLE_CYCLES`, default 6: cycles waited after the last low phase before capture; must satisfy `GO_LOW_CYCLES + SETTLE_CYCLES ≥ 7`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: level request, sampled only in IDLE.
- `a_in`, `b_in`, `c_in`, `x_in` in 8 each: operands, sampled on the accepting edge.
- `data_result` in 8: result output of the evaluator.
- `data_in` out 8: operand currently presented to the evaluator.
- `go` out 1: go signal to the evaluator.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when `result` is updated.
- `result` out 8: captured evaluator result, held until the next capture.

## Operation
- Reset values: state=IDLE, `go`=0, `data_in`=0, `busy`=0, `done`=0, `result`=0, operand regs=0, index=0, counter=0.
- States:
  - IDLE
    - `start`=1: latch all four operands, index←0, counter←`GO_HIGH_CYCLES`-1, go to DRIVE_HI.
    - Otherwise stay in IDLE.
  - DRIVE_HI: `go`=1; at counter 0, counter←`GO_LOW_CYCLES`-1, go to DRIVE_LO.
  - DRIVE_LO: `go`=0; at counter 0:
    - index<3: index+1, counter←`GO_HIGH_CYCLES`-1, go to DRIVE_HI.
    - index=3: counter←`SETTLE_CYCLES`-1, go to SETTLE.
  - SETTLE: `go`=0; at counter 0, `result`←`data_result`, go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Otherwise the counter decrements by 1 each cycle.
- `data_in` is a register driven from the latched operand selected by index: 0=A, 1=B, 2=C, 3=X.
  - Stable through the whole high and low phase of its operand.
  - Forced to 0 in IDLE, SETTLE and DONE.
- `go` is registered with no combinational path from `start`.
- Operand inputs are ignored after acceptance; changing switches mid-run has no effect.
- `start` while busy is ignored, with no queuing.
- `start` still high on return to IDLE launches a new run on the next edge (back-to-back).
- `reset` mid-run: the next cycle is IDLE with `go`=0 and `result`=0.
  - The evaluator shares the same reset net, inverted at the top, so both restart in their load-A state.
- Arithmetic: index is 2 bits. The counter width is `$clog2` of the largest parameter (minimum 1). No wrap beyond index 3.

## Timing
- Accept `start` at edge E0. `go` rises in cycle 1, the first cycle after E0.
- Per operand: `GO_HIGH_CYCLES` high cycles, then `GO_LOW_CYCLES` low cycles.
- `result` is valid and `done`=1 in cycle 4·(H+L)+S+1, which is 23 with defaults.
- Evaluator latency budget:
  - The evaluator leaves its X-wait state on the edge ending the first X low cycle.
  - It loads `data_result` 5 edges later.
  - The parameter constraint guarantees capture occurs at least one cycle after that.
- `busy` rises in cycle 1 and falls in the cycle after DONE.
- Minimum start-to-start period is 4(H+L)+S+2 cycles.

## Structure
- Shared package `poly_pkg`:
  - State enum: IDLE, DRIVE_HI, DRIVE_LO, SETTLE, DONE.
  - Operand index constants: OP_A=0, OP_B=1, OP_C=2, OP_X=3.
  - Default phase lengths.
- One sub-module: `phase_counter`, a loadable down-counter with a `zero` flag, parameterised width.
- The top FSM and operand mux stay in `poly_operand_feeder`.

## Test plan
The bench connects the feeder to a behavioural evaluator model (shared reset) computing C·X²+B·X+A mod 256.
- A=1, B=2, C=3, X=4, start one cycle, defaults:
  - `go` high in cycles 1-2, 5-6, 9-10, 13-14.
  - `data_in` =1, 2, 3, 4 per operand.
  - `done` in cycle 23 with `result`=0x39.
- A=0xFF, B=0x10, C=0x20, X=0x10 → `result`=(0x2000+0x100+0xFF) mod 256=0xFF. Checks 8-bit wrap.
- `start` held high continuously:
  - Two runs back-to-back.
  - The second `go` rise comes exactly 2 cycles after the first `done`.
  - `result` holds the first value until the second `done`.
- `start` pulsed in cycle 8 of a run and operands changed mid-run: no extra run, and `data_in` still shows the originally latched values.
- `reset` asserted in cycle 10 → cycle 11: `go`=0, `busy`=0, `result`=0. A fresh run then produces the correct 0x39.
- `GO_HIGH_CYCLES`=1, `GO_LOW_CYCLES`=1, `SETTLE_CYCLES`=6:
  - `done` in cycle 15.
  - Correct result for A=1, B=2, C=3, X=4.
